// File: rtl/cache_line_collector.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_collector
// Description : Queues block descriptors and tags returned cache lines in
//               raster order with absolute line coordinates and a last flag.
//               Optional line-order check: define CACHE_COLLECT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_collector #(
    parameter int LINE_WDTH  = 64,
    parameter int BASE_WDTH  = 9,
    parameter int DESC_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 desc_valid,
    output logic                 desc_ready,
    input  logic [1:0]           desc_dx,
    input  logic [1:0]           desc_dy,
    input  logic [BASE_WDTH-1:0] desc_base_x,
    input  logic [BASE_WDTH-1:0] desc_base_y,
    input  logic                 line_valid,
    output logic                 line_ready,
    input  logic [LINE_WDTH-1:0] line_data,
    input  logic [1:0]           line_tag_x,
    input  logic [1:0]           line_tag_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LINE_WDTH-1:0] out_data,
    output logic [BASE_WDTH-1:0] out_x,
    output logic [BASE_WDTH-1:0] out_y,
    output logic                 out_last,
    output logic                 block_done,
    output logic                 busy,
    output logic                 seq_err
);

    localparam int c_PTR_W  = $clog2(DESC_DEPTH);
    localparam int c_DESC_W = 4 + 2 * BASE_WDTH;
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DESC_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_DESC_W-1:0]  r_fifo [DESC_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_push;
    logic                 w_pop;
    logic [c_DESC_W-1:0]  w_head;

    logic [1:0]           r_dx;
    logic [1:0]           r_dy;
    logic [1:0]           r_cx;
    logic [1:0]           r_cy;
    logic [BASE_WDTH-1:0] r_bx;
    logic [BASE_WDTH-1:0] r_by;

    logic                 r_out_valid;
    logic [LINE_WDTH-1:0] r_out_data;
    logic [BASE_WDTH-1:0] r_out_x;
    logic [BASE_WDTH-1:0] r_out_y;
    logic                 r_out_last;
    logic                 r_block_done;

    logic                 w_line_ready;
    logic                 w_accept;
    logic                 w_is_last;

    // Descriptor FIFO; readiness comes from the registered count only
    assign desc_ready = (r_count != c_FULL);
    assign w_push     = desc_valid & desc_ready;
    assign w_head     = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {desc_dx, desc_dy, desc_base_x, desc_base_y};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_line_ready = (r_state == S_ACTIVE) & (~r_out_valid | out_ready);
    assign w_accept     = line_valid & w_line_ready;
    assign w_is_last    = (r_cx == r_dx) && (r_cy == r_dy);
    assign line_ready   = w_line_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_accept && w_is_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Raster walk: counters return to 0 after the last line so they never pass dx/dy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dx <= '0;
            r_dy <= '0;
            r_bx <= '0;
            r_by <= '0;
            r_cx <= '0;
            r_cy <= '0;
        end else if (w_pop) begin
            {r_dx, r_dy, r_bx, r_by} <= w_head;
            r_cx <= '0;
            r_cy <= '0;
        end else if (w_accept) begin
            if (w_is_last) begin
                r_cx <= '0;
                r_cy <= '0;
            end else if (r_cx == r_dx) begin
                r_cx <= '0;
                r_cy <= r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_last   <= 1'b0;
            r_block_done <= 1'b0;
        end else begin
            r_block_done <= r_out_valid & out_ready & r_out_last;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= line_data;
                r_out_x     <= r_bx + {{(BASE_WDTH-2){1'b0}}, r_cx};
                r_out_y     <= r_by + {{(BASE_WDTH-2){1'b0}}, r_cy};
                r_out_last  <= w_is_last;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign out_last   = r_out_last;
    assign block_done = r_block_done;
    assign busy       = (r_state == S_ACTIVE) | (r_count != '0) | r_out_valid;

`ifdef CACHE_COLLECT_CHECK_EN
    logic r_seq_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq_err <= 1'b0;
        end else if (w_accept && ({line_tag_x, line_tag_y} != {r_cx, r_cy})) begin
            r_seq_err <= 1'b1;
        end
    end

    assign seq_err = r_seq_err;
`else
    logic w_unused_tags;
    assign w_unused_tags = ^{line_tag_x, line_tag_y};
    assign seq_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_line_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_line_collector
// Description : Table-driven and scoreboard bench for cache_line_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_collector;

    localparam int LW = 64;
    localparam int BW = 9;
    localparam int DD = 4;
`ifdef CACHE_COLLECT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          desc_valid;
    logic          desc_ready;
    logic [1:0]    desc_dx;
    logic [1:0]    desc_dy;
    logic [BW-1:0] desc_base_x;
    logic [BW-1:0] desc_base_y;
    logic          line_valid;
    logic          line_ready;
    logic [LW-1:0] line_data;
    logic [1:0]    line_tag_x;
    logic [1:0]    line_tag_y;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_data;
    logic [BW-1:0] out_x;
    logic [BW-1:0] out_y;
    logic          out_last;
    logic          block_done;
    logic          busy;
    logic          seq_err;

    always #5 clk = ~clk;

    cache_line_collector #(
        .LINE_WDTH (LW),
        .BASE_WDTH (BW),
        .DESC_DEPTH(DD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_dx    (desc_dx),
        .desc_dy    (desc_dy),
        .desc_base_x(desc_base_x),
        .desc_base_y(desc_base_y),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_data  (line_data),
        .line_tag_x (line_tag_x),
        .line_tag_y (line_tag_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_last   (out_last),
        .block_done (block_done),
        .busy       (busy),
        .seq_err    (seq_err)
    );

    typedef struct {
        logic [LW-1:0] data;
        logic [BW-1:0] x;
        logic [BW-1:0] y;
        logic          last;
    } exp_t;

    typedef struct {
        logic [1:0]    dx;
        logic [1:0]    dy;
        logic [BW-1:0] bx;
        logic [BW-1:0] by;
        logic [BW-1:0] lx;
        logic [BW-1:0] ly;
    } vec_t;

    exp_t          sb[$];
    exp_t          mon_e;
    vec_t          vecs[6];
    int            total = 0;
    int            bad = 0;
    int            wait_cycles = 0;
    bit            mon_en = 1'b0;
    bit            exp_done = 1'b0;
    logic [BW-1:0] last_x = '0;
    logic [BW-1:0] last_y = '0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, req);
        end
    endtask

    // Output-side monitor: one scoreboard pop per transfer, block_done one cycle after a last transfer
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check(block_done == exp_done, "block_done", block_done, exp_done);
                exp_done = out_valid & out_ready & out_last & ~reset;
                if (out_valid && out_ready && !reset) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_out", out_x, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check(out_data == mon_e.data, "out_data", out_data, mon_e.data);
                        check(out_x == mon_e.x, "out_x", out_x, mon_e.x);
                        check(out_y == mon_e.y, "out_y", out_y, mon_e.y);
                        check(out_last == mon_e.last, "out_last", out_last, mon_e.last);
                        if (out_last) begin
                            last_x = out_x;
                            last_y = out_y;
                        end
                    end
                end
            end
        end
    end

    task automatic send_desc(input logic [1:0] dx, input logic [1:0] dy,
                             input logic [BW-1:0] bx, input logic [BW-1:0] by);
        int n;
        n = 0;
        desc_valid  = 1'b1;
        desc_dx     = dx;
        desc_dy     = dy;
        desc_base_x = bx;
        desc_base_y = by;
        #1;
        while (!desc_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(desc_ready == 1'b1, "desc_timeout", desc_ready, 1);
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic send_line(input logic [LW-1:0] d, input logic [1:0] tx, input logic [1:0] ty,
                             input logic [BW-1:0] ex, input logic [BW-1:0] ey, input bit el);
        int n;
        n = 0;
        line_valid = 1'b1;
        line_data  = d;
        line_tag_x = tx;
        line_tag_y = ty;
        #1;
        while (!line_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        wait_cycles += n;
        check(line_ready == 1'b1, "line_timeout", line_ready, 1);
        sb.push_back('{d, ex, ey, el});
        @(negedge clk);
        line_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(sb.size() == 0, "drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state();
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        check(out_data == '0, "rst_out_data", out_data, 0);
        check(out_x == '0, "rst_out_x", out_x, 0);
        check(out_y == '0, "rst_out_y", out_y, 0);
        check(out_last == 1'b0, "rst_out_last", out_last, 0);
        check(block_done == 1'b0, "rst_block_done", block_done, 0);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(seq_err == 1'b0, "rst_seq_err", seq_err, 0);
        check(desc_ready == 1'b1, "rst_desc_ready", desc_ready, 1);
        check(line_ready == 1'b0, "rst_line_ready", line_ready, 0);
    endtask

    initial begin
        vecs[0] = '{2'd1, 2'd1, 9'd10,  9'd20,  9'd11,  9'd21};
        vecs[1] = '{2'd0, 2'd0, 9'd511, 9'd0,   9'd511, 9'd0};
        vecs[2] = '{2'd1, 2'd0, 9'd511, 9'd5,   9'd0,   9'd5};
        vecs[3] = '{2'd3, 2'd3, 9'd100, 9'd200, 9'd103, 9'd203};
        vecs[4] = '{2'd2, 2'd1, 9'd508, 9'd511, 9'd510, 9'd0};
        vecs[5] = '{2'd3, 2'd0, 9'd509, 9'd3,   9'd0,   9'd3};

        reset       = 1'b1;
        desc_valid  = 1'b0;
        desc_dx     = '0;
        desc_dy     = '0;
        desc_base_x = '0;
        desc_base_y = '0;
        line_valid  = 1'b0;
        line_data   = '0;
        line_tag_x  = '0;
        line_tag_y  = '0;
        out_ready   = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        #1;
        check(desc_ready == 1'b1, "post_rst_desc_ready", desc_ready, 1);
        check(line_ready == 1'b0, "post_rst_line_ready", line_ready, 0);
        @(negedge clk);

        // Table of blocks, including base wrap-around and the single-line case
        for (int i = 0; i < 6; i++) begin
            send_desc(vecs[i].dx, vecs[i].dy, vecs[i].bx, vecs[i].by);
            for (int y = 0; y <= int'(vecs[i].dy); y++) begin
                for (int x = 0; x <= int'(vecs[i].dx); x++) begin
                    send_line({$urandom, $urandom}, 2'(x), 2'(y),
                              vecs[i].bx + BW'(x), vecs[i].by + BW'(y),
                              (x == int'(vecs[i].dx)) && (y == int'(vecs[i].dy)));
                    if (x == 0 && y == 0) wait_cycles = 0;
                end
            end
            check(wait_cycles == 0, "throughput", wait_cycles, 0);
            drain();
            check(last_x == vecs[i].lx, "block_last_x", last_x, vecs[i].lx);
            check(last_y == vecs[i].ly, "block_last_y", last_y, vecs[i].ly);
        end

        // FIFO fill while the FSM waits on a line for block d0
        send_desc(2'd0, 2'd0, 9'd1, 9'd2);
        send_desc(2'd0, 2'd0, 9'd3, 9'd4);
        send_desc(2'd0, 2'd0, 9'd5, 9'd6);
        send_desc(2'd0, 2'd0, 9'd7, 9'd8);
        send_desc(2'd0, 2'd0, 9'd9, 9'd10);
        desc_valid  = 1'b1;
        desc_dx     = 2'd1;
        desc_dy     = 2'd0;
        desc_base_x = 9'd20;
        desc_base_y = 9'd30;
        for (int k = 0; k < 3; k++) begin
            #1;
            check(desc_ready == 1'b0, "fifo_full", desc_ready, 0);
            check(busy == 1'b1, "busy_full", busy, 1);
            @(negedge clk);
        end
        fork
            send_desc(2'd1, 2'd0, 9'd20, 9'd30);
            send_line(64'h1111, 2'd0, 2'd0, 9'd1, 9'd2, 1'b1);
        join
        send_line(64'h2222, 2'd0, 2'd0, 9'd3, 9'd4, 1'b1);
        send_line(64'h3333, 2'd0, 2'd0, 9'd5, 9'd6, 1'b1);
        send_line(64'h4444, 2'd0, 2'd0, 9'd7, 9'd8, 1'b1);
        send_line(64'h5555, 2'd0, 2'd0, 9'd9, 9'd10, 1'b1);
        send_line(64'h6666, 2'd0, 2'd0, 9'd20, 9'd30, 1'b0);
        send_line(64'h7777, 2'd1, 2'd0, 9'd21, 9'd30, 1'b1);
        drain();

        // Downstream stall for three cycles mid-block
        send_desc(2'd3, 2'd0, 9'd50, 9'd60);
        send_line(64'hA5A5_0000_0000_0000, 2'd0, 2'd0, 9'd50, 9'd60, 1'b0);
        send_line(64'hA5A5_0000_0000_0001, 2'd1, 2'd0, 9'd51, 9'd60, 1'b0);
        out_ready  = 1'b0;
        line_valid = 1'b1;
        line_data  = 64'hA5A5_0000_0000_0002;
        line_tag_x = 2'd2;
        line_tag_y = 2'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check(line_ready == 1'b0, "stall_line_ready", line_ready, 0);
            check(out_valid == 1'b1, "stall_out_valid", out_valid, 1);
            check(out_x == 9'd51, "stall_out_x", out_x, 51);
            check(out_data == 64'hA5A5_0000_0000_0001, "stall_out_data", out_data,
                  64'hA5A5_0000_0000_0001);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send_line(64'hA5A5_0000_0000_0002, 2'd2, 2'd0, 9'd52, 9'd60, 1'b0);
        send_line(64'hA5A5_0000_0000_0003, 2'd3, 2'd0, 9'd53, 9'd60, 1'b1);
        drain();

        // Reset in the middle of a block with two descriptors queued
        send_desc(2'd3, 2'd0, 9'd70, 9'd80);
        send_desc(2'd1, 2'd1, 9'd90, 9'd91);
        send_desc(2'd0, 2'd0, 9'd92, 9'd93);
        send_line(64'hBEEF_0000, 2'd0, 2'd0, 9'd70, 9'd80, 1'b0);
        send_line(64'hBEEF_0001, 2'd1, 2'd0, 9'd71, 9'd80, 1'b0);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        @(negedge clk);
        send_desc(2'd1, 2'd0, 9'd7, 9'd8);
        send_line(64'hCAFE_0000, 2'd0, 2'd0, 9'd7, 9'd8, 1'b0);
        send_line(64'hCAFE_0001, 2'd1, 2'd0, 9'd8, 9'd8, 1'b1);
        drain();
        check(last_x == 9'd8, "post_rst_last_x", last_x, 8);

        // Out-of-order tags: only flagged when the check logic is built in
        check(seq_err == 1'b0, "seq_err_clean", seq_err, 0);
        send_desc(2'd1, 2'd0, 9'd30, 9'd40);
        send_line(64'hD00D_0000, 2'd0, 2'd0, 9'd30, 9'd40, 1'b0);
        #1;
        check(seq_err == 1'b0, "seq_err_line1", seq_err, 0);
        @(negedge clk);
        send_line(64'hD00D_0001, 2'd0, 2'd0, 9'd31, 9'd40, 1'b1);
        #1;
        check(seq_err == CHK, "seq_err_line2", seq_err, CHK);
        drain();
        check(seq_err == CHK, "seq_err_sticky", seq_err, CHK);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
